// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and frame field widths.
// Pure declarations; no timing or flow control of its own.
package imem_loader_pkg;

  localparam int LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  // True while a frame is being received; drives both byte_ready and busy.
  function automatic logic is_loading(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs 4 little-endian bytes into a 32-bit word; word_valid pulses combinationally on the 4th byte.
// Zero latency to the word; never stalls, byte_en is the upstream handshake already qualified.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] shift;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lane  <= 2'd0;
      shift <= 24'd0;
    end else if (byte_en) begin
      lane  <= lane + 2'd1;
      shift <= {byte_data, shift[23:8]};
    end
  end

  // After three shifts the earliest byte sits in shift[7:0], so the 4th byte completes the word on top.
  assign word_valid = byte_en && (lane == 2'd3);
  assign word       = {byte_data, shift};

endmodule

// File: rtl/imem_loader.sv
// Boot-link frame receiver writing little-endian words to instruction memory at 0,4,8,...
// Writes issue one cycle after the word's last byte; byte_ready depends only on state, never stalls on writes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int IDX_WIDTH = $clog2(DEPTH_WORDS + 1);

  state_t                 state, state_nxt;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   len_full;
  logic [IDX_WIDTH-1:0]   word_idx;
  logic [7:0]             csum;
  logic                   hs, load_start, pack_en, last_word;
  logic                   word_valid;
  logic [31:0]            word;

  assign byte_ready = is_loading(state);
  assign busy       = is_loading(state);
  assign cpu_hold   = busy;
  assign done       = (state == DONE);
  assign error      = (state == ERROR);

  assign hs         = byte_valid && byte_ready;
  assign load_start = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign pack_en    = hs && (state == DATA);
  assign len_full   = {byte_data, len[7:0]};
  assign last_word  = (LEN_WIDTH'(word_idx) + LEN_WIDTH'(1)) == len;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_start),
    .byte_en    (pack_en),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = LEN_LO;
      LEN_LO:            if (hs) state_nxt = LEN_HI;
      LEN_HI: begin
        if (hs) begin
          if (len_full > LEN_WIDTH'(DEPTH_WORDS)) state_nxt = ERROR;
          else if (len_full == '0)                state_nxt = CSUM;
          else                                    state_nxt = DATA;
        end
      end
      DATA:              if (word_valid && last_word) state_nxt = CSUM;
      CSUM:              if (hs) state_nxt = (byte_data == csum) ? DONE : ERROR;
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len       <= '0;
      word_idx  <= '0;
      csum      <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= word_valid;
      if (load_start) begin
        word_idx <= '0;
        csum     <= 8'd0;
      end
      if (hs && (state == LEN_LO)) len[7:0]           <= byte_data;
      if (hs && (state == LEN_HI)) len[LEN_WIDTH-1:8] <= byte_data;
      if (pack_en) csum <= csum ^ byte_data;
      // Address and data only move on a write, so they hold between strobes.
      if (word_valid) begin
        mem_addr  <= ADDR_WIDTH'({word_idx, 2'b00});
        mem_wdata <= word;
        word_idx  <= word_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame stimulus with a write scoreboard; the monitor consumes expected writes independently.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, mem_we, busy, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.ADDR_WIDTH(32), .DEPTH_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         exp_q[$];
  logic [31:0] words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %h data %h, want no write (t=%0t)", mem_addr, mem_wdata, $time);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", mem_addr, w.addr);
        check("wr_data", mem_wdata, w.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
    check({tag, "_mem_addr"},   mem_addr,        32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
  endtask

  // All tasks start and finish at posedge+1.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy",  32'(busy),  32'd1);
    check("start_done",  32'(done),  32'd0);
    check("start_error", 32'(error), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit hs;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        if (busy && ($urandom_range(0, 2) == 0)) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    do begin
      hs = byte_ready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 50);
    byte_valid = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout: byte %h not accepted, want accept within 50 cycles", b);
    end
  endtask

  // Reference: frame = len LE, payload bytes LE per word, XOR checksum; writes only when len fits.
  task automatic run_load(input int len, input bit bad, input bit gaps);
    logic [7:0]  frame[$];
    logic [7:0]  cs;
    logic [31:0] wd;
    bit          fits, ok;
    wr_t         w;
    fits = (len <= 256);
    ok   = fits && !bad;
    frame.push_back(8'(len));
    frame.push_back(8'(len >> 8));
    if (fits) begin
      cs = 8'd0;
      for (int i = 0; i < len; i++) begin
        wd = words[i];
        for (int k = 0; k < 4; k++) begin
          frame.push_back(wd[8*k +: 8]);
          cs = cs ^ wd[8*k +: 8];
        end
        w.addr = 32'(i * 4);
        w.data = wd;
        exp_q.push_back(w);
      end
      frame.push_back(bad ? (cs ^ 8'h01) : cs);
    end
    do_start();
    foreach (frame[i]) send_byte(frame[i], gaps);
    check("end_busy",       32'(busy),       32'd0);
    check("end_cpu_hold",   32'(cpu_hold),   32'd0);
    check("end_byte_ready", 32'(byte_ready), 32'd0);
    check("end_done",       32'(done),       32'(ok));
    check("end_error",      32'(error),      32'(!ok));
    @(posedge clk); #1;
    check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom());
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    wr_t w0;
    int  len;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    words.delete();
    words.push_back(32'h00500013);
    words.push_back(32'h00a00093);
    run_load(2, 1'b0, 1'b0);   // good frame, checksum 0x70
    run_load(2, 1'b1, 1'b0);   // bad checksum, writes still happen
    run_load(0, 1'b0, 1'b0);   // empty frame
    run_load(257, 1'b0, 1'b0); // oversize, rejected after LEN_HI
    run_load(2, 1'b0, 1'b1);   // throttled with ignored start pulses

    random_words(256);
    run_load(256, 1'b0, 1'b0); // largest legal frame

    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(0, 6);
      random_words(len);
      run_load(len, ($urandom_range(0, 3) == 0), 1'b1);
    end

    // Reset in the middle of DATA: first word already written, rest abandoned.
    words.delete();
    words.push_back(32'h00500013);
    words.push_back(32'h00a00093);
    w0.addr = 32'd0;
    w0.data = 32'h00500013;
    exp_q.push_back(w0);
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    check("midreset_writes_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    run_load(2, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("final_writes_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
